// File: rtl/input_vc_buffer_pkg.sv
// Shared flit-format constants and defaults for the input VC buffer.
// Flits are numbered with bit 0 as the LSB; the tail marker is bit FLIT_TAIL.
package input_vc_buffer_pkg;

  localparam int unsigned FLIT_SIZE     = 16;
  localparam int unsigned FLIT_TAIL     = 0;  // 1 = last flit of a packet
  localparam int unsigned FLIT_DST      = 8;  // LSB of the destination field
  localparam int unsigned FLIT_DST_W    = 4;
  localparam int unsigned BUF_DEPTH     = 4;
  localparam int unsigned LOG_BUF_DEPTH = 2;

  typedef enum logic {StIdle, StPkt} pkt_state_e;

  function automatic logic flit_is_tail(input logic [FLIT_SIZE-1:0] flit);
    return flit[FLIT_TAIL];
  endfunction

endpackage

// File: rtl/input_vc_buffer_flit_fifo.sv
// flit_fifo: storage, read/write pointers and occupancy for one VC.
// Ports:
//   clk, reset_n      clock, async active-low reset (memory cleared too)
//   push_i, wdata_i   write request and flit; ignored when full
//   pop_i             read request; ignored when empty
//   rdata_o           head flit (mem[rd_ptr])
//   count_o           registered occupancy 0..DEPTH
//   full_o, empty_o   decoded from count only
module flit_fifo
  import input_vc_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = BUF_DEPTH,
  parameter int unsigned LOG_DEPTH = LOG_BUF_DEPTH,
  parameter int unsigned WIDTH     = FLIT_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic [LOG_DEPTH:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam logic [LOG_DEPTH:0] DepthCnt = (LOG_DEPTH + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  // A full FIFO never accepts, even when the head is popped in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + LOG_DEPTH'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (LOG_DEPTH + 1)'(1);
      2'b01:   count_d = count_q - (LOG_DEPTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // Cleared so the head output is never X after reset.
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/input_vc_buffer.sv
// input_vc_buffer: receive-side flit buffer for one input port / one VC.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   link_valid          upstream presents link_flit this cycle
//   link_flit           flit from upstream
//   credit_out          level, 1 = a slot is free (registered decode)
//   is_new_flit         head flit valid
//   flit_out            head flit to the VC allocator
//   credit_for_input    allocator grant, pops the head
//   in_packet           head forwarded, tail not yet forwarded
//   count               occupancy 0..DEPTH
//   overflow_err        sticky, set by a write while full
module input_vc_buffer
  import input_vc_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = BUF_DEPTH,
  parameter int unsigned LOG_DEPTH = LOG_BUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 link_valid,
  input  logic [FLIT_SIZE-1:0] link_flit,
  output logic                 credit_out,
  output logic                 is_new_flit,
  output logic [FLIT_SIZE-1:0] flit_out,
  input  logic                 credit_for_input,
  output logic                 in_packet,
  output logic [LOG_DEPTH:0]   count,
  output logic                 overflow_err
);

  logic       full, empty, pop;
  pkt_state_e state_q;
  logic       in_packet_q;
  logic       overflow_q;

  flit_fifo #(
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOG_DEPTH),
    .WIDTH     (FLIT_SIZE)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (link_valid),
    .wdata_i (link_flit),
    .pop_i   (credit_for_input),
    .rdata_o (flit_out),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Both derive from the registered count: no path from link_valid/grant.
  assign credit_out  = !full;
  assign is_new_flit = !empty;
  assign pop         = credit_for_input && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      in_packet_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (link_valid && full) overflow_q <= 1'b1;
      if (pop) begin
        unique case (state_q)
          StIdle: begin
            // A tail popped in idle is a single-flit packet.
            if (!flit_is_tail(flit_out)) begin
              state_q     <= StPkt;
              in_packet_q <= 1'b1;
            end
          end
          StPkt: begin
            if (flit_is_tail(flit_out)) begin
              state_q     <= StIdle;
              in_packet_q <= 1'b0;
            end
          end
          default: begin
            state_q     <= StIdle;
            in_packet_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_packet    = in_packet_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_input_vc_buffer.sv
module tb_input_vc_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        link_valid;
  logic [15:0] link_flit;
  logic        credit_out;
  logic        is_new_flit;
  logic [15:0] flit_out;
  logic        credit_for_input;
  logic        in_packet;
  logic [2:0]  count;
  logic        overflow_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  input_vc_buffer #(
    .DEPTH     (4),
    .LOG_DEPTH (2)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .link_valid       (link_valid),
    .link_flit        (link_flit),
    .credit_out       (credit_out),
    .is_new_flit      (is_new_flit),
    .flit_out         (flit_out),
    .credit_for_input (credit_for_input),
    .in_packet        (in_packet),
    .count            (count),
    .overflow_err     (overflow_err)
  );

  typedef struct {
    logic        lv;
    logic [15:0] fl;
    logic        gr;
    logic        e_cr;
    logic        e_new;
    logic [15:0] e_flit;
    logic        e_pkt;
    logic [2:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  localparam int NVec = 14;
  vec_t vecs [NVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".credit_out"},   32'(credit_out),   32'd1);
    check({tag, ".is_new_flit"},  32'(is_new_flit),  32'd0);
    check({tag, ".count"},        32'(count),        32'd0);
    check({tag, ".in_packet"},    32'(in_packet),    32'd0);
    check({tag, ".overflow_err"}, 32'(overflow_err), 32'd0);
    check({tag, ".flit_out"},     32'(flit_out),     32'd0);
  endtask

  task automatic step(input logic lv, input logic [15:0] fl, input logic gr);
    link_valid       = lv;
    link_flit        = fl;
    credit_for_input = gr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    link_valid       = 1'b0;
    link_flit        = '0;
    credit_for_input = 1'b0;
    reset_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [15:0] sent [$];
  logic [15:0] model_q [$];

  initial begin
    // lv, flit, grant | credit, new, head, in_packet, count, overflow
    vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0}; // idle
    vecs[1]  = '{1'b1, 16'h0A00, 1'b0, 1'b1, 1'b1, 16'h0A00, 1'b0, 3'd1, 1'b0}; // head
    vecs[2]  = '{1'b1, 16'h0B00, 1'b0, 1'b1, 1'b1, 16'h0A00, 1'b0, 3'd2, 1'b0};
    vecs[3]  = '{1'b1, 16'h0C00, 1'b0, 1'b1, 1'b1, 16'h0A00, 1'b0, 3'd3, 1'b0};
    vecs[4]  = '{1'b1, 16'h0D01, 1'b0, 1'b0, 1'b1, 16'h0A00, 1'b0, 3'd4, 1'b0}; // fills
    vecs[5]  = '{1'b1, 16'h0E00, 1'b0, 1'b0, 1'b1, 16'h0A00, 1'b0, 3'd4, 1'b1}; // overflow
    vecs[6]  = '{1'b1, 16'h0F00, 1'b1, 1'b1, 1'b1, 16'h0B00, 1'b1, 3'd3, 1'b1}; // full: pop only
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0C00, 1'b1, 3'd2, 1'b1};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0D01, 1'b1, 3'd1, 1'b1};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b1}; // tail pop
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b1}; // empty pop
    vecs[11] = '{1'b1, 16'h0101, 1'b0, 1'b1, 1'b1, 16'h0101, 1'b0, 3'd1, 1'b1};
    vecs[12] = '{1'b1, 16'h0200, 1'b1, 1'b1, 1'b1, 16'h0200, 1'b0, 3'd1, 1'b1}; // single-flit pkt
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd0, 1'b1}; // head pop

    do_reset();
    check_reset_vals("reset");

    for (int i = 0; i < NVec; i++) begin
      step(vecs[i].lv, vecs[i].fl, vecs[i].gr);
      check($sformatf("v%0d.credit_out", i), 32'(credit_out), 32'(vecs[i].e_cr));
      check($sformatf("v%0d.is_new_flit", i), 32'(is_new_flit), 32'(vecs[i].e_new));
      if (vecs[i].e_new)
        check($sformatf("v%0d.flit_out", i), 32'(flit_out), 32'(vecs[i].e_flit));
      check($sformatf("v%0d.in_packet", i), 32'(in_packet), 32'(vecs[i].e_pkt));
      check($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d.overflow_err", i), 32'(overflow_err), 32'(vecs[i].e_ovf));
    end

    // Streaming at occupancy 2: every flit leaves two edges after it entered.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      sent.push_back(16'h1000 + 16'(i * 2));
      model_q.push_back(16'h1000 + 16'(i * 2));
      step(1'b1, 16'h1000 + 16'(i * 2), 1'b0);
    end
    check("stream.prefill_count", 32'(count), 32'd2);
    for (int i = 2; i < 22; i++) begin
      logic [15:0] v;
      v = 16'h1000 + 16'(i * 2);
      check($sformatf("stream%0d.head_residency", i), 32'(flit_out), 32'(sent[i - 2]));
      sent.push_back(v);
      step(1'b1, v, 1'b1);
      model_q.push_back(v);
      void'(model_q.pop_front());
      check($sformatf("stream%0d.count", i), 32'(count), 32'd2);
      check($sformatf("stream%0d.head", i), 32'(flit_out), 32'(model_q[0]));
      check($sformatf("stream%0d.credit", i), 32'(credit_out), 32'd1);
    end
    check("stream.in_packet", 32'(in_packet), 32'd1);

    // Asynchronous reset with three flits stored, mid-packet.
    do_reset();
    step(1'b1, 16'h2000, 1'b0);
    step(1'b1, 16'h2100, 1'b0);
    step(1'b1, 16'h2200, 1'b0);
    step(1'b1, 16'h2300, 1'b1);
    step(1'b0, 16'h0000, 1'b0);
    check("pre_async.count", 32'(count), 32'd3);
    check("pre_async.in_packet", 32'(in_packet), 32'd1);
    check("pre_async.head", 32'(flit_out), 32'h2100);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 16'h0000, 1'b0);
    check("post_async.count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_vc_buffer.md
# input_vc_buffer

Receive-side flit buffer for one input port and one VC of a router. Accepts flits from the upstream link, holds them in a FIFO and presents the head flit to the per-input VC allocator as `flit_in` / `is_new_flit`. Pops the head when the allocator returns `credit_for_input`. Drives the level credit that the upstream router's allocator samples as its `nxt_routers_credit` bit.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `LOG_DEPTH`, 2: log2(`DEPTH`).

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `link_valid`, in, 1: upstream presents a flit this cycle.
- `link_flit`, in, [1:`FLIT_SIZE`]: flit from upstream.
- `credit_out`, out, 1: level; 1 = a slot is free. Wired to upstream `nxt_routers_credit[port]`.
- `is_new_flit`, out, 1: FIFO non-empty; head flit valid.
- `flit_out`, out, [1:`FLIT_SIZE`]: head flit, wired to allocator `flit_in`.
- `credit_for_input`, in, 1: allocator grant; pops the head.
- `in_packet`, out, 1: a head flit has been forwarded and its tail has not.
- `count`, out, [0:`LOG_DEPTH`]: occupancy, 0..`DEPTH`.
- `overflow_err`, out, 1: sticky; a write arrived while full.

## Operation
- Push: `link_valid`=1 and `count`<`DEPTH`. The flit is written at the write pointer and `wr_ptr` increments modulo `DEPTH`.
- Overflow: `link_valid`=1 and `count`=`DEPTH`. The flit is dropped, `overflow_err` sets, and it holds until reset. This applies even if a pop happens in the same cycle; a full buffer never accepts.
- Pop: `credit_for_input`=1 and `is_new_flit`=1. `rd_ptr` increments modulo `DEPTH`. A pop request while empty is ignored and causes no error.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Occupancy: `count` is the registered value. `count_next = count + push − pop`.
- `credit_out = (count < DEPTH)`. It is decoded from registers only, with no combinational path from `link_valid` or `credit_for_input`.
- `flit_out = mem[rd_ptr]`. Its value when `is_new_flit`=0 is don't-care, but it must not be X after reset, so memory is reset to 0.
- Packet FSM, two states:
  - IDLE → PKT on a pop of a flit whose `FLIT_TAIL` bit is 0.
  - PKT → IDLE on a pop of a flit whose `FLIT_TAIL` bit is 1.
  - A tail pop in IDLE (single-flit packet) stays in IDLE.
  - A non-tail pop in PKT stays in PKT.
- `in_packet` = (state == PKT).
- Reset values: `count`=0, pointers 0, `credit_out`=1, `is_new_flit`=0, `flit_out`=0, `in_packet`=0, `overflow_err`=0.
- Reset asserted mid-packet or with the FIFO non-empty discards all contents and returns everything to the reset values above.

## Timing
- Write-to-visible latency is 1 cycle. A flit pushed at edge t appears on `is_new_flit`/`flit_out` after edge t. There is no empty bypass.
- Pop takes effect at the edge on which `credit_for_input`=1. The next head is visible after that edge.
- Credit loop: upstream may send in any cycle where it samples `credit_out`=1. The registered `count` already includes all prior pushes, so no more than `DEPTH` flits are ever in flight.
- `credit_out` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop from a full FIFO.
- Full throughput: one push and one pop per cycle are sustainable indefinitely at any occupancy between 1 and `DEPTH`−1.

## Structure
- Shared package/`constants.v` holds `FLIT_SIZE`, `FLIT_TAIL`, `FLIT_DST`, plus new `BUF_DEPTH` and `LOG_BUF_DEPTH` defaults.
- Sub-module `flit_fifo` implements the storage, pointers and count.
- `input_vc_buffer` adds the credit decode, packet FSM and overflow flag.

## Test plan
- Reset, then idle → `credit_out`=1, `is_new_flit`=0, `count`=0, `in_packet`=0.
- Push 4 flits (`DEPTH`=4) with grant held at 0 → `count`=4, `credit_out`=0 after the 4th edge; a 5th push sets `overflow_err`=1 and `count` stays 4.
- From full, pulse the grant for one cycle → head pops, `count`=3, `credit_out`=1 the next cycle, remaining order FIFO-preserved.
- Continuous push and grant for 20 cycles at `count`=2 → `count` stays 2 and flits exit in order with 2-cycle residency.
- Pop head (tail=0), body, then tail=1 → `in_packet` goes 0→1 after the head pop and 1→0 after the tail pop; a single tail-only flit leaves `in_packet`=0.
- Assert `reset_n`=0 asynchronously with 3 flits stored mid-packet → all outputs take reset values immediately, without waiting for `clk`.
